// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//   Read-side consumer for a CDC FIFO with a registered pre-ack protocol.
//   It drives the FIFO ack, captures narrow beats and packs RATIO of them
//   into one wide word presented on a valid/ready output.
//
//   Ports
//     clk_i         clock (FIFO read clock)
//     reset_i       synchronous, active-high reset
//     fifo_data_i   FIFO read data (IN_WIDTH)
//     fifo_valid_i  FIFO read valid
//     fifo_ack_o    FIFO read ack (combinational from registered state)
//     flush_i       synchronous discard of the partial word
//     out_data_o    packed word (IN_WIDTH*RATIO)
//     out_valid_o   out_data_o valid
//     out_ready_i   downstream accept (transfer on valid & ready)
//     partial_o     a partial word is being accumulated
module fifo_word_packer #(
    parameter int IN_WIDTH   = 8,
    parameter int RATIO      = 4,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [IN_WIDTH-1:0]       fifo_data_i,
    input  logic                      fifo_valid_i,
    output logic                      fifo_ack_o,
    input  logic                      flush_i,
    output logic [IN_WIDTH*RATIO-1:0] out_data_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      partial_o
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int FILL_W    = $clog2(RATIO);

    localparam logic [FILL_W-1:0] LAST_LANE = FILL_W'(RATIO - 1);
    localparam logic [FILL_W:0]   LIMIT     = (FILL_W + 1)'(RATIO - 1);

    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 ack_q;

    logic [FILL_W:0]      inflight;
    logic                 last;
    logic                 capture;
    logic [FILL_W-1:0]    lane;
    logic [OUT_WIDTH-1:0] word;

    always_comb begin
        // Beats already held plus the one whose data arrives this cycle.
        inflight = {1'b0, fill_q} + {{FILL_W{1'b0}}, ack_q};
        last     = (fill_q == LAST_LANE);

        // Only request a beat that can complete a word when the output
        // register is known to be free; no path from out_ready_i.
        fifo_ack_o = !reset_i && !flush_i &&
                     ((inflight < LIMIT) || (!out_valid_q && !(ack_q && last)));

        // Data is only real when we acked it on the previous edge.
        capture = ack_q && fifo_valid_i && !flush_i;

        lane = (BIG_ENDIAN != 0) ? (LAST_LANE - fill_q) : fill_q;

        word = acc_q;
        for (int l = 0; l < RATIO; l++) begin
            if (lane == FILL_W'(l)) begin
                word[l*IN_WIDTH +: IN_WIDTH] = fifo_data_i;
            end
        end
    end

    always_comb begin
        fill_d      = fill_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        if (capture) begin
            if (last) begin
                out_data_d  = word;
                out_valid_d = 1'b1;
                fill_d      = '0;
            end else begin
                acc_d  = word;
                fill_d = fill_q + 1'b1;
            end
        end

        if (flush_i) begin
            fill_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fill_q      <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ack_q       <= fifo_ack_o;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign partial_o   = (fill_q != '0);

endmodule
